// File: rtl/aes_pkg.sv
// Shared definitions for the AES round controllers: state encoding, round sizing
// and flag bit positions.
package aes_pkg;

    // Default round count (AES-128) and width of the round-key index.
    localparam int unsigned NrDefault = 10;
    localparam int unsigned RndW      = 4;

    // Bit positions in the controller flag vector, shared with the encrypt side.
    localparam int unsigned FlagKeyExp  = 0;
    localparam int unsigned FlagKeyCap  = 1;
    localparam int unsigned FlagInit    = 2;
    localparam int unsigned FlagMid     = 3;
    localparam int unsigned FlagLst     = 4;
    localparam int unsigned FlagInvStep = 5;
    localparam int unsigned FlagDone    = 6;
    localparam int unsigned FlagW       = 7;

    // Controller states; codes 3'b110 and 3'b111 are unused and recover to StIdle.
    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StKeyExp    = 3'd1,
        StInitRound = 3'd2,
        StMidRound  = 3'd3,
        StLstRound  = 3'd4,
        StDone      = 3'd5
    } state_e;

endpackage

// File: rtl/aes_inv_ctrl.sv
// Round controller for the AES inverse cipher. Runs an optional forward key
// expansion to reach the last round key, then walks the rounds back down to key 0.
module aes_inv_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR = NrDefault
) (
    input  logic            iClk,
    input  logic            iRsn,
    input  logic            iStAes,
    input  logic            iNewKey,
    output logic            oKeyExpFlag,
    output logic            oKeyCapture,
    output logic            oInitRoundFlag,
    output logic            oMidRoundFlag,
    output logic            oLstRoundFlag,
    output logic            oKeyInvStep,
    output logic [RndW-1:0] oRoundNum,
    output logic            oBusy,
    output logic            oAesDone
);

    localparam logic [RndW-1:0] NrR = RndW'(NR);

    state_e            r_state;
    state_e            w_state_next;
    logic [RndW-1:0]   r_round;
    logic [RndW-1:0]   w_round_next;
    logic              r_lst_key_ok;
    logic [FlagW-1:0]  w_flags;
    logic              w_busy;

    // Next-state selection.
    always_comb begin
        w_state_next = StIdle;
        case (r_state)
            StIdle: begin
                if (!iStAes) begin
                    w_state_next = StIdle;
                end else if (iNewKey || !r_lst_key_ok) begin
                    w_state_next = StKeyExp;
                end else begin
                    w_state_next = StInitRound;
                end
            end
            StKeyExp:    w_state_next = (r_round == NrR) ? StInitRound : StKeyExp;
            StInitRound: w_state_next = StMidRound;
            StMidRound:  w_state_next = (r_round == RndW'(1)) ? StLstRound : StMidRound;
            StLstRound:  w_state_next = StDone;
            StDone:      w_state_next = StIdle;
            default:     w_state_next = StIdle;
        endcase
    end

    // Round index follows the state being entered: load on entry, count while staying.
    always_comb begin
        w_round_next = '0;
        case (w_state_next)
            StKeyExp:    w_round_next = (r_state == StKeyExp) ? r_round + RndW'(1) : RndW'(1);
            StInitRound: w_round_next = NrR;
            StMidRound:  w_round_next = r_round - RndW'(1);
            default:     w_round_next = '0;
        endcase
    end

    // State register.
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Round-key index register.
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            r_round <= '0;
        end else begin
            r_round <= w_round_next;
        end
    end

    // Last-round-key cache: valid once an expansion pass has captured the final key.
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            r_lst_key_ok <= 1'b0;
        end else if (r_state == StKeyExp && r_round == NrR) begin
            r_lst_key_ok <= 1'b1;
        end
    end

    // Moore decode of phase flags and busy from the state register.
    always_comb begin
        w_flags = '0;
        w_busy  = 1'b1;
        case (r_state)
            StIdle: w_busy = 1'b0;
            StKeyExp: begin
                w_flags[FlagKeyExp] = 1'b1;
                w_flags[FlagKeyCap] = (r_round == NrR);
            end
            StInitRound: begin
                w_flags[FlagInit]    = 1'b1;
                w_flags[FlagInvStep] = 1'b1;
            end
            StMidRound: begin
                w_flags[FlagMid]     = 1'b1;
                w_flags[FlagInvStep] = 1'b1;
            end
            StLstRound: w_flags[FlagLst]  = 1'b1;
            StDone:     w_flags[FlagDone] = 1'b1;
            default:    w_busy = 1'b0;
        endcase
    end

    assign oKeyExpFlag    = w_flags[FlagKeyExp];
    assign oKeyCapture    = w_flags[FlagKeyCap];
    assign oInitRoundFlag = w_flags[FlagInit];
    assign oMidRoundFlag  = w_flags[FlagMid];
    assign oLstRoundFlag  = w_flags[FlagLst];
    assign oKeyInvStep    = w_flags[FlagInvStep];
    assign oAesDone       = w_flags[FlagDone];
    assign oBusy          = w_busy;
    assign oRoundNum      = r_round;

endmodule

// File: tb/tb_aes_inv_ctrl.sv
// Self-checking bench for aes_inv_ctrl: a per-block list model of the expected
// output sequence, directed scenarios and randomized back-to-back blocks.
module tb_aes_inv_ctrl;
    import aes_pkg::*;

    localparam int unsigned NR = 10;

    logic       iClk;
    logic       iRsn;
    logic       iStAes;
    logic       iNewKey;
    logic       oKeyExpFlag;
    logic       oKeyCapture;
    logic       oInitRoundFlag;
    logic       oMidRoundFlag;
    logic       oLstRoundFlag;
    logic       oKeyInvStep;
    logic [3:0] oRoundNum;
    logic       oBusy;
    logic       oAesDone;

    aes_inv_ctrl #(.NR(NR)) dut (
        .iClk           (iClk),
        .iRsn           (iRsn),
        .iStAes         (iStAes),
        .iNewKey        (iNewKey),
        .oKeyExpFlag    (oKeyExpFlag),
        .oKeyCapture    (oKeyCapture),
        .oInitRoundFlag (oInitRoundFlag),
        .oMidRoundFlag  (oMidRoundFlag),
        .oLstRoundFlag  (oLstRoundFlag),
        .oKeyInvStep    (oKeyInvStep),
        .oRoundNum      (oRoundNum),
        .oBusy          (oBusy),
        .oAesDone       (oAesDone)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Observation vector: {kexp, kcap, init, mid, lst, invstep, busy, done, round[3:0]}
    logic [11:0] obs;
    assign obs = {oKeyExpFlag, oKeyCapture, oInitRoundFlag, oMidRoundFlag, oLstRoundFlag,
                  oKeyInvStep, oBusy, oAesDone, oRoundNum};

    int          tests = 0;
    int          fails = 0;
    bit          model_ok = 1'b0;
    logic [11:0] exp_q[$];

    function automatic logic [11:0] pack(input bit ke, input bit cap, input bit ini,
                                         input bit mid, input bit lst, input bit inv,
                                         input bit busy, input bit done, input int rnd);
        logic [3:0] r;
        r = 4'(rnd);
        return {ke, cap, ini, mid, lst, inv, busy, done, r};
    endfunction

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Expected per-cycle outputs of one block, from the edge after the start sample.
    task automatic build(input bit expand);
        exp_q.delete();
        if (expand) begin
            for (int r = 1; r <= int'(NR); r++) exp_q.push_back(pack(1, r == int'(NR), 0, 0, 0, 0, 1, 0, r));
        end
        exp_q.push_back(pack(0, 0, 1, 0, 0, 1, 1, 0, NR));
        for (int r = int'(NR) - 1; r >= 1; r--) exp_q.push_back(pack(0, 0, 0, 1, 0, 1, 1, 0, r));
        exp_q.push_back(pack(0, 0, 0, 0, 1, 0, 1, 0, 0));
        exp_q.push_back(pack(0, 0, 0, 0, 0, 0, 1, 1, 0));
    endtask

    // Entered and left at a falling edge inside an IDLE cycle.
    // mode: 0 quiet, 1 random stray starts, 2 start held high. abort_at: cycle to reset in.
    task automatic run_block(input bit nk, input int mode, input int abort_at, input string tag);
        bit expand;
        expand = nk || !model_ok;
        build(expand);
        iStAes  = 1'b1;
        iNewKey = nk;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge iClk);
            check($sformatf("%s_c%0d", tag, i + 1), obs, exp_q[i]);
            if (i == abort_at) begin
                #2 iRsn = 1'b0;
                #1 check({tag, "_async_rst"}, obs, 12'h000);
                model_ok = 1'b0;
                iStAes   = 1'b0;
                @(negedge iClk);
                check({tag, "_rst_held"}, obs, 12'h000);
                iRsn = 1'b1;
                return;
            end
            iStAes  = (mode == 2) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            iNewKey = 1'($urandom_range(0, 1));
        end
        if (expand) model_ok = 1'b1;
        @(negedge iClk);
        check({tag, "_idle"}, obs, 12'h000);
        iStAes = 1'b0;
    endtask

    initial begin
        iRsn    = 1'b0;
        iStAes  = 1'b0;
        iNewKey = 1'b0;
        @(negedge iClk);
        check("reset", obs, 12'h000);
        iRsn = 1'b1;
        @(negedge iClk);
        check("post_reset", obs, 12'h000);

        run_block(1'b1, 0, -1, "expand");
        run_block(1'b0, 0, -1, "cached");
        run_block(1'b0, 2, -1, "start_held");
        run_block(1'b0, 1, -1, "stray");
        run_block(1'b1, 0, -1, "newkey_recache");
        run_block(1'b0, 0, 5, "abort_mid5");
        run_block(1'b0, 0, -1, "after_rst");

        for (int i = 0; i < 100; i++) begin
            @(negedge iClk);
            check("idle_hold", obs, 12'h000);
        end

        // Illegal state code: flags drop at once, IDLE on the next edge.
        force dut.r_state = state_e'(3'b111);
        #1 check("illegal_flags", obs & 12'hFD0, 12'h000);
        release dut.r_state;
        @(negedge iClk);
        check("illegal_recover", obs, 12'h000);
        run_block(1'b0, 0, -1, "post_illegal");

        for (int b = 0; b < 20; b++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                @(negedge iClk);
                check("rand_gap", obs, 12'h000);
            end
            run_block(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), -1,
                      $sformatf("rand%0d", b));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Overall time bound so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
